// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-requester memory port arbiter.
// Opcode/funct3 values are shared with the core controller.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_RESP      = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_IF = 1'b0,
    REQ_LS = 1'b1
  } req_id_t;

  localparam logic [2:0] FUNCT3_WORD = 3'b010;

  localparam logic [6:0] OPCODE_LOAD  = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;

  localparam logic [2:0] FUNCT3_SB  = 3'b000;
  localparam logic [2:0] FUNCT3_SH  = 3'b001;
  localparam logic [2:0] FUNCT3_SW  = 3'b010;
  localparam logic [2:0] FUNCT3_LBU = 3'b100;
  localparam logic [2:0] FUNCT3_LHU = 3'b101;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_IF) ? REQ_LS : REQ_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the shared memory port.
// Handshake: a requester raises *_req with stable fields and holds both until it sees a
// one-cycle *_gnt; read data returns later on a one-cycle *_rvalid with *_rdata.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem_arb_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              ls_req;
  logic              ls_we;
  logic [2:0]        ls_funct3;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic              ls_gnt;
  logic              ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;

  logic              write_mem;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] write_address;
  logic [DATA_W-1:0] write_data;
  logic [ADDR_W-1:0] read_address;
  logic [DATA_W-1:0] read_data;

  arb_state_t        dbg_state;

  modport master (
    input  if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, read_data,
    output if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    output write_mem, funct3, write_address, write_data, read_address, dbg_state
  );

  modport slave (
    output if_req, if_addr, ls_req, ls_we, ls_funct3, ls_addr, ls_wdata, read_data,
    input  if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata,
    input  write_mem, funct3, write_address, write_data, read_address, dbg_state
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-input round-robin picker: on a tie the requester that did not win last time wins.
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic    req_if_i,
  input  logic    req_ls_i,
  input  req_id_t last_i,
  output req_id_t winner_o,
  output logic    valid_o
);

  always_comb begin
    winner_o = REQ_IF;
    valid_o  = req_if_i | req_ls_i;
    if (req_if_i && req_ls_i) begin
      winner_o = other_req(last_i);
    end else if (req_ls_i) begin
      winner_o = REQ_LS;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises instruction-fetch and load/store accesses onto one memory port.
// All port outputs are registered; a read waits READ_LAT cycles before capture.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  localparam int              CNT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(READ_LAT - 1);

  arb_state_t        state_q;
  req_id_t           last_q;
  req_id_t           owner_q;
  logic              is_store_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              if_gnt_q;
  logic              if_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic              ls_gnt_q;
  logic              ls_rvalid_q;
  logic [DATA_W-1:0] ls_rdata_q;
  logic              write_mem_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] write_address_q;
  logic [DATA_W-1:0] write_data_q;
  logic [ADDR_W-1:0] read_address_q;

  req_id_t           pick_winner;
  logic              pick_valid;

  rr_pick2 u_pick (
    .req_if_i (bus.if_req),
    .req_ls_i (bus.ls_req),
    .last_i   (last_q),
    .winner_o (pick_winner),
    .valid_o  (pick_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      last_q          <= REQ_IF;
      owner_q         <= REQ_IF;
      is_store_q      <= 1'b0;
      cnt_q           <= '0;
      if_gnt_q        <= 1'b0;
      if_rvalid_q     <= 1'b0;
      if_rdata_q      <= '0;
      ls_gnt_q        <= 1'b0;
      ls_rvalid_q     <= 1'b0;
      ls_rdata_q      <= '0;
      write_mem_q     <= 1'b0;
      funct3_q        <= FUNCT3_WORD;
      write_address_q <= '0;
      write_data_q    <= '0;
      read_address_q  <= '0;
    end else begin
      // Pulses last exactly one cycle unless a state below re-asserts them.
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      write_mem_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_ISSUE;
            last_q  <= pick_winner;
            owner_q <= pick_winner;
            if (pick_winner == REQ_IF) begin
              if_gnt_q       <= 1'b1;
              is_store_q     <= 1'b0;
              read_address_q <= bus.if_addr;
              funct3_q       <= FUNCT3_WORD;
            end else begin
              ls_gnt_q   <= 1'b1;
              is_store_q <= bus.ls_we;
              funct3_q   <= bus.ls_funct3;
              if (bus.ls_we) begin
                write_mem_q     <= 1'b1;
                write_address_q <= bus.ls_addr;
                write_data_q    <= bus.ls_wdata;
              end else begin
                read_address_q <= bus.ls_addr;
              end
            end
          end
        end

        ST_ISSUE: begin
          cnt_q   <= '0;
          state_q <= is_store_q ? ST_IDLE : ST_READ_WAIT;
        end

        ST_READ_WAIT: begin
          // Last wait cycle is cycle G+READ_LAT, when memory data is valid.
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_RESP;
            if (owner_q == REQ_IF) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= bus.read_data;
            end else begin
              ls_rvalid_q <= 1'b1;
              ls_rdata_q  <= bus.read_data;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_RESP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.if_gnt        = if_gnt_q;
  assign bus.if_rvalid     = if_rvalid_q;
  assign bus.if_rdata      = if_rdata_q;
  assign bus.ls_gnt        = ls_gnt_q;
  assign bus.ls_rvalid     = ls_rvalid_q;
  assign bus.ls_rdata      = ls_rdata_q;
  assign bus.write_mem     = write_mem_q;
  assign bus.funct3        = funct3_q;
  assign bus.write_address = write_address_q;
  assign bus.write_data    = write_data_q;
  assign bus.read_address  = read_address_q;
  assign bus.dbg_state     = state_q;

endmodule
